// File: rtl/sfu_writeback.sv
// Drains the per-column SFU output registers into psum SRAM, one packed word per strobe.
// Optional 8-bit unsigned lane saturation is enabled with `define SFU_WB_SAT8_EN.

module sfu_wb_lane #(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout
);
`ifdef SFU_WB_SAT8_EN
    // Lanes are signed psums; clamp to 0..255 and zero-extend.
    always_comb begin
        if (din[psum_bw-1])
            dout = '0;
        else if (din > psum_bw'(255))
            dout = psum_bw'(255);
        else
            dout = din;
    end
`else
    assign dout = din;
`endif
endmodule

module sfu_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_nij = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     stall,
    output logic                     sfu_rd,
    input  logic [col*psum_bw-1:0]   sfu_data,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_bw-1:0]       sram_addr,
    output logic [col*psum_bw-1:0]   sram_d,
    output logic                     busy,
    output logic                     done
);
    localparam int CNT_W  = $clog2(out_nij + 1);
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                      state, state_nx;
    logic                        issue;
    logic [STAGES:0]             vld_pipe;  // [0] strobe out, [1] sfu_data valid
    logic [CNT_W-1:0]            rd_cnt, wr_cnt;
    logic [addr_bw-1:0]          base_q;
    logic [col-1:0][psum_bw-1:0] lane_in, lane_out;

    assign sfu_rd  = vld_pipe[0];
    assign lane_in = sfu_data;

    for (genvar c = 0; c < col; c++) begin : g_lane
        sfu_wb_lane #(.psum_bw(psum_bw)) u_lane (
            .din  (lane_in[c]),
            .dout (lane_out[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = READ;
            READ: begin
                if (rd_cnt == CNT_W'(out_nij)) state_nx = DRAIN;
                else if (!stall)               issue    = 1'b1;
            end
            DRAIN: if (wr_cnt == CNT_W'(out_nij)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Writes are driven purely by the valid pipe, so strobes already issued
    // always land even if stall rises behind them.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            base_q    <= '0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_d    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
            busy     <= (state_nx == READ) || (state_nx == DRAIN);
            done     <= (state_nx == DONE);
            sram_cen <= ~vld_pipe[1];
            sram_wen <= ~vld_pipe[1];
            if (state == IDLE && start) begin
                base_q <= base_addr;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
            if (issue) rd_cnt <= rd_cnt + 1'b1;
            if (vld_pipe[1]) begin
                sram_addr <= base_q + addr_bw'(wr_cnt);
                sram_d    <= lane_out;
                wr_cnt    <= wr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sfu_writeback.sv
// Randomized drain runs against a word-list reference model of sfu_writeback.
module tb_sfu_writeback;
    localparam int COL = 8, PW = 16, NIJ = 16, AW = 11;

    logic              clk = 1'b0;
    logic              reset, start, stall;
    logic [AW-1:0]     base_addr;
    logic              sfu_rd, sram_cen, sram_wen, busy, done;
    logic [COL*PW-1:0] sfu_data = '0;
    logic [AW-1:0]     sram_addr;
    logic [COL*PW-1:0] sram_d;

    int n_chk  = 0;
    int n_pass = 0;

    sfu_writeback #(.col(COL), .psum_bw(PW), .out_nij(NIJ), .addr_bw(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stall(stall),
        .sfu_rd(sfu_rd), .sfu_data(sfu_data), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_d(sram_d), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SFU model: a list of words, one popped per strobe, presented the next cycle.
    logic [COL*PW-1:0] words [0:1023];
    int ptr = 0;
    always @(posedge clk) begin
        if (sfu_rd) begin
            sfu_data <= words[ptr % 1024];
            ptr      <= ptr + 1;
        end
    end

    function automatic logic [PW-1:0] ref_lane(input logic [PW-1:0] v);
`ifdef SFU_WB_SAT8_EN
        int s;
        s = int'($signed(v));
        if (s < 0)   return '0;
        if (s > 255) return PW'(255);
        return v;
`else
        return v;
`endif
    endfunction

    function automatic logic [COL*PW-1:0] ref_word(input logic [COL*PW-1:0] w);
        logic [COL*PW-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PW +: PW] = ref_lane(w[c*PW +: PW]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run(input string tag, input logic [AW-1:0] base, input int mode,
                       input int st_from, input int st_len, input int restart_at, input int rst_at);
        int p0, nw, nrd, ndone, first_rd, last_rd, last_wr, done_cyc;
        bit finished;
        logic [AW-1:0]     ea, last_addr;
        logic [COL*PW-1:0] last_d;
        logic [PW-1:0]     v;
        logic [PW-1:0]     satv [3];
        satv = '{16'h012C, 16'h00FF, 16'h0000};
        p0 = ptr;
        for (int k = 0; k < NIJ; k++)
            for (int c = 0; c < COL; c++) begin
                if (mode == 1) v = PW'(16 * k + c);
                else if (mode == 2) v = satv[(k + c) % 3];
                else case ($urandom_range(0, 2))
                    0: v = PW'($urandom_range(0, 300));
                    1: v = PW'(-int'($urandom_range(1, 500)));
                    default: v = PW'($urandom);
                endcase
                words[(p0 + k) % 1024][c*PW +: PW] = v;
            end
        nw = 0; nrd = 0; ndone = 0; first_rd = -1; last_rd = -1; last_wr = -100; done_cyc = -100;
        finished = 0; last_addr = '0; last_d = '0;
        @(negedge clk); start = 1'b1; base_addr = base;
        @(negedge clk); start = 1'b0; base_addr = ~base;
        for (int cyc = 0; cyc < 120 && !finished; cyc++) begin
            chk({tag, " busy"}, busy, (ndone == 0) && !done);
            if (sfu_rd) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                nrd++;
            end
            if (!sram_cen) begin
                ea = base + AW'(nw);
                chk({tag, " wen"}, sram_wen, 1'b0);
                chk({tag, " addr"}, sram_addr, ea);
                chk({tag, " data"}, sram_d, ref_word(words[(p0 + nw) % 1024]));
                if (nw == 0) chk({tag, " rd_to_wr"}, cyc - first_rd, 2);
                last_wr = cyc; last_addr = ea; last_d = ref_word(words[(p0 + nw) % 1024]);
                nw++;
            end
            if (done) begin
                chk({tag, " done_lat"}, cyc - last_wr, 1);
                ndone++;
                done_cyc = cyc;
            end
            if (ndone > 0 && cyc == done_cyc + 2) begin
                chk({tag, " idle_cen"}, {sram_cen, sram_wen}, 2'b11);
                chk({tag, " idle_hold"}, {sram_addr, sram_d}, {last_addr, last_d});
                finished = 1;
            end
            if (rst_at >= 0 && nw == rst_at) begin
                reset = 1'b1;
                @(negedge clk); reset = 1'b0;
                chk({tag, " rst_outs"}, {sram_cen, busy, sfu_rd}, 3'b100);
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk({tag, " rst_quiet"}, {sram_cen, done, sfu_rd, busy}, 4'b1000);
                end
                finished = 1;
            end
            if (!finished) begin
                stall = (cyc >= st_from) && (cyc < st_from + st_len);
                start = (cyc == restart_at);
                base_addr = AW'($urandom);
                @(negedge clk);
            end
        end
        stall = 1'b0; start = 1'b0;
        chk({tag, " finished"}, finished, 1'b1);
        if (rst_at < 0) begin
            chk({tag, " n_writes"}, nw, NIJ);
            chk({tag, " n_reads"}, nrd, NIJ);
            chk({tag, " n_done"}, ndone, 1);
            chk({tag, " rd_span"}, last_rd - first_rd + 1, NIJ + st_len);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {sfu_rd, sram_cen, sram_wen, busy, done}, 5'b01100);
        chk("reset_data", {sram_addr, sram_d}, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ctl", {sfu_rd, sram_cen, sram_wen, busy, done}, 5'b01100);

        run("basic",   11'h040, 1, 0, 0, -1, -1);
        run("stall",   AW'($urandom), 0, 3, 4, -1, -1);
        run("restart", 11'h100, 0, 0, 0, 5, -1);
        run("wrap",    11'h7FE, 0, 0, 0, -1, -1);
        run("midrst",  11'h200, 0, 0, 0, -1, 5);
        run("clean",   11'h300, 0, 0, 0, -1, -1);
        run("sat",     11'h010, 2, 0, 0, -1, -1);
        run("rand",    AW'($urandom), 0, $urandom_range(2, 10), $urandom_range(1, 5), -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
